// File: rtl/ec_parity_sched_pkg.sv
// Shared sizing defaults, FSM state encoding and width helper for the
// bitmatrix parity scheduler.
package ec_parity_sched_pkg;

    localparam int DEF_W             = 4;
    localparam int DEF_PACKET_LENGTH = 8;
    localparam int DEF_K_MAX         = 8;
    localparam int DEF_M_MAX         = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_MULT      = 2'd2,
        ST_OUT       = 2'd3
    } state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ec_parity_sched_and_xor.sv
// GF(2) bitmatrix-by-block product: output packet i is the XOR of every data
// packet j whose column j has bit i set.
module and_xor_unit #(
    parameter int W             = 4,
    parameter int PACKET_LENGTH = 8
) (
    input  logic [W*W-1:0]             cols,
    input  logic [W*PACKET_LENGTH-1:0] data_packet,
    output logic [W*PACKET_LENGTH-1:0] product
);

    always_comb begin
        product = '0;
        for (int j = 0; j < W; j++) begin
            for (int i = 0; i < W; i++) begin
                if (cols[j*W + i]) begin
                    product[i*PACKET_LENGTH +: PACKET_LENGTH] =
                        product[i*PACKET_LENGTH +: PACKET_LENGTH] ^
                        data_packet[j*PACKET_LENGTH +: PACKET_LENGTH];
                end
            end
        end
    end

endmodule

// File: rtl/ec_parity_sched.sv
// Erasure-code parity scheduler: accepts k data blocks, folds each into m
// parity accumulators via bitmatrix reads, then streams the m parity blocks out.
module ec_parity_sched
    import ec_parity_sched_pkg::*;
#(
    parameter int  W             = DEF_W,
    parameter int  PACKET_LENGTH = DEF_PACKET_LENGTH,
    parameter int  K_MAX         = DEF_K_MAX,
    parameter int  M_MAX         = DEF_M_MAX,
    localparam int DW            = W * PACKET_LENGTH,
    localparam int KW            = $clog2(K_MAX + 1),
    localparam int MW            = $clog2(M_MAX + 1),
    localparam int AW            = cnt_w(K_MAX * M_MAX),
    localparam int IW            = cnt_w(M_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_num,
    input  logic [MW-1:0] m_num,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          bm_rd_en,
    output logic [AW-1:0] bm_rd_addr,
    input  logic [W*W-1:0] bm_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output state_e        dbg_state
);

    localparam int DCW = cnt_w(K_MAX);

    state_e                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [MW-1:0]            m_q, m_d;
    logic [IW-1:0]            p_q, p_d, o_q, o_d, rd_p;
    logic [DCW-1:0]           d_q, d_d;
    logic [DW-1:0]            data_q, data_d, product;
    logic [M_MAX-1:0][DW-1:0] acc_q, acc_d;
    logic                     cfg_ok, p_last, d_last, o_last;

    and_xor_unit #(.W(W), .PACKET_LENGTH(PACKET_LENGTH)) u_and_xor (
        .cols        (bm_rd_data),
        .data_packet (data_q),
        .product     (product)
    );

    assign cfg_ok = (k_num != '0) && (k_num <= KW'(K_MAX)) &&
                    (m_num != '0) && (m_num <= MW'(M_MAX));
    assign p_last = (MW'(p_q) == m_q - MW'(1));
    assign d_last = (KW'(d_q) == k_q - KW'(1));
    assign o_last = (MW'(o_q) == m_q - MW'(1));
    assign dbg_state = state_q;

    // Both handshakes transfer on a rising edge where valid and ready are both
    // high; out_valid/out_idx/out_data hold steady until that edge. The read
    // issued with bm_rd_en returns data in the very next (MULT) cycle.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        m_d       = m_q;
        p_d       = p_q;
        d_d       = d_q;
        o_d       = o_q;
        data_d    = data_q;
        acc_d     = acc_q;
        rd_p      = '0;
        in_ready  = 1'b0;
        bm_rd_en  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_data  = '0;
        busy      = 1'b1;
        done      = 1'b0;
        cfg_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (cfg_ok) begin
                        k_d     = k_num;
                        m_d     = m_num;
                        p_d     = '0;
                        d_d     = '0;
                        o_d     = '0;
                        acc_d   = '0;
                        state_d = ST_WAIT_DATA;
                    end else begin
                        cfg_err = 1'b1;
                    end
                end
            end
            ST_WAIT_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d   = in_data;
                    bm_rd_en = 1'b1;
                    p_d      = '0;
                    state_d  = ST_MULT;
                end
            end
            ST_MULT: begin
                acc_d[p_q] = acc_q[p_q] ^ product;
                if (!p_last) begin
                    bm_rd_en = 1'b1;
                    rd_p     = p_q + IW'(1);
                    p_d      = p_q + IW'(1);
                end else if (!d_last) begin
                    d_d     = d_q + DCW'(1);
                    p_d     = '0;
                    state_d = ST_WAIT_DATA;
                end else begin
                    p_d     = '0;
                    o_d     = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                out_idx   = o_q;
                out_data  = acc_q[o_q];
                if (out_ready) begin
                    if (o_last) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        o_d = o_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        bm_rd_addr = bm_rd_en ? AW'(int'(rd_p) * K_MAX + int'(d_q)) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            m_q     <= '0;
            p_q     <= '0;
            d_q     <= '0;
            o_q     <= '0;
            data_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m_q     <= m_d;
            p_q     <= p_d;
            d_q     <= d_d;
            o_q     <= o_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_ec_parity_sched.sv
// Self-checking bench for ec_parity_sched: bitmatrix memory model, reference
// parity model feeding an expected queue, and a negedge scoreboard.
module tb_ec_parity_sched;

    localparam int W     = 4;
    localparam int PL    = 8;
    localparam int K_MAX = 4;
    localparam int M_MAX = 2;
    localparam int DATW  = W * PL;
    localparam int BMW   = W * W;
    localparam int AW    = 3;
    localparam int IW    = 1;
    localparam int KW    = 3;
    localparam int MW    = 2;
    localparam int EW    = DATW + IW + 1;

    logic            clk = 1'b0;
    logic            rst, start;
    logic [KW-1:0]   k_num;
    logic [MW-1:0]   m_num;
    logic            in_valid, in_ready;
    logic [DATW-1:0] in_data;
    logic            bm_rd_en;
    logic [AW-1:0]   bm_rd_addr;
    logic [BMW-1:0]  bm_rd_data;
    logic            out_valid, out_ready;
    logic [IW-1:0]   out_idx;
    logic [DATW-1:0] out_data;
    logic            busy, done, cfg_err;
    ec_parity_sched_pkg::state_e dbg_state;

    logic [BMW-1:0]  bm_mem [K_MAX*M_MAX];
    logic [DATW-1:0] blocks [K_MAX];
    logic [EW-1:0]   exp_q[$];
    logic [AW-1:0]   exp_addr_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int in_hs_cnt = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int rd_extra = 0;
    int out_extra = 0;

    ec_parity_sched #(.W(W), .PACKET_LENGTH(PL), .K_MAX(K_MAX), .M_MAX(M_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_num      (k_num),
        .m_num      (m_num),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .bm_rd_en   (bm_rd_en),
        .bm_rd_addr (bm_rd_addr),
        .bm_rd_data (bm_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bitmatrix memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bm_rd_en) bm_rd_data <= bm_mem[bm_rd_addr];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATW-1:0] gf_mult(input logic [BMW-1:0] bm, input logic [DATW-1:0] blk);
        logic [DATW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (bm[j*W + i]) r[i*PL +: PL] = r[i*PL +: PL] ^ blk[j*PL +: PL];
        return r;
    endfunction

    // Scoreboard: reads, accepts and parity handshakes observed mid-cycle.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (in_valid && in_ready) in_hs_cnt++;
            if (done) done_cnt++;
            if (bm_rd_en) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) rd_extra++;
                else check("rd_addr", bm_rd_addr, exp_addr_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) out_extra++;
                else begin
                    e = exp_q.pop_front();
                    check("out_idx", out_idx, e[DATW +: IW]);
                    check("out_data", out_data, e[DATW-1:0]);
                    check("done", done, e[EW-1]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_in_ready"}, in_ready, 0);
        check({pfx, "_bm_rd_en"}, bm_rd_en, 0);
        check({pfx, "_bm_rd_addr"}, bm_rd_addr, 0);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_out_idx"}, out_idx, 0);
        check({pfx, "_out_data"}, out_data, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_cfg_err"}, cfg_err, 0);
    endtask

    task automatic bad_cfg(input int k, input int m, input string tag);
        @(posedge clk); #1;
        start = 1'b1; k_num = KW'(k); m_num = MW'(m);
        @(negedge clk);
        check({tag, "_err"}, cfg_err, 1);
        check({tag, "_busy"}, busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_err_clr"}, cfg_err, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic start_job(input int k, input int m, input bit use_model);
        for (int p = 0; p < m; p++) begin
            logic [DATW-1:0] acc;
            acc = '0;
            for (int d = 0; d < k; d++) acc = acc ^ gf_mult(bm_mem[p*K_MAX + d], blocks[d]);
            if (use_model) exp_q.push_back({(p == m - 1), IW'(p), acc});
        end
        for (int d = 0; d < k; d++)
            for (int p = 0; p < m; p++) exp_addr_q.push_back(AW'(p*K_MAX + d));
        @(posedge clk); #1;
        start = 1'b1; k_num = KW'(k); m_num = MW'(m);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("job_busy", busy, 1);
        check("job_wait_ready", in_ready, 1);
    endtask

    task automatic send_block(input logic [DATW-1:0] blk, input int gap);
        int n;
        n = 0;
        @(posedge clk); #1;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = blk;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        check("in_accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mult_in_ready", in_ready, 0);
        check("mult_busy", busy, 1);
    endtask

    task automatic recv_outputs(input int m, input int hmin, input int hmax);
        for (int o = 0; o < m; o++) begin
            int n;
            int hold;
            n = 0;
            hold = $urandom_range(hmin, hmax);
            out_ready = 1'b0;
            while (!out_valid && n < 200) begin @(negedge clk); n++; end
            check("out_valid_timeout", out_valid, 1);
            if (!out_valid) return;
            for (int h = 0; h < hold; h++) begin
                if (exp_q.size() > 0) begin
                    check("bp_valid", out_valid, 1);
                    check("bp_idx", out_idx, exp_q[0][DATW +: IW]);
                    check("bp_data", out_data, exp_q[0][DATW-1:0]);
                end
                @(negedge clk);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_job(input int k, input int m, input int gmax, input int hmax);
        int d0;
        d0 = done_cnt;
        start_job(k, m, 1'b1);
        for (int d = 0; d < k; d++) send_block(blocks[d], $urandom_range(0, gmax));
        recv_outputs(m, 0, hmax);
        check("job_done_cnt", done_cnt - d0, 1);
        check("job_idle_busy", busy, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < K_MAX*M_MAX; i++) bm_mem[i] = BMW'($urandom_range(0, 65535));
        for (int i = 0; i < K_MAX; i++) blocks[i] = $urandom();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int h0;
        int r0;
        rst = 1'b1; start = 1'b0; k_num = '0; m_num = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < K_MAX*M_MAX; i++) bm_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        bad_cfg(0, 1, "cfg_k0");
        bad_cfg(1, 3, "cfg_m3");
        bad_cfg(5, 1, "cfg_k5");
        bad_cfg(2, 0, "cfg_m0");

        // Identity matrix, three constant blocks.
        for (int i = 0; i < K_MAX*M_MAX; i++) bm_mem[i] = 16'h8421;
        blocks[0] = 32'h1111_1111;
        blocks[1] = 32'h2222_2222;
        blocks[2] = 32'h4444_4444;
        d0 = done_cnt;
        start_job(3, 2, 1'b0);
        exp_q.push_back({1'b0, IW'(0), 32'h7777_7777});
        exp_q.push_back({1'b1, IW'(1), 32'h7777_7777});
        for (int d = 0; d < 3; d++) send_block(blocks[d], d);
        recv_outputs(2, 1, 2);
        check("ident_done_cnt", done_cnt - d0, 1);

        // Zero matrix, random data.
        for (int i = 0; i < K_MAX*M_MAX; i++) bm_mem[i] = '0;
        for (int i = 0; i < K_MAX; i++) blocks[i] = $urandom();
        h0 = in_hs_cnt;
        start_job(4, 1, 1'b0);
        exp_q.push_back({1'b1, IW'(0), 32'h0});
        for (int d = 0; d < 4; d++) send_block(blocks[d], 0);
        recv_outputs(1, 0, 1);
        check("zero_in_hs", in_hs_cnt - h0, 4);

        // Read address order with back-to-back data.
        fill_random();
        r0 = rd_cnt;
        run_job(2, 2, 0, 0);
        check("addr_rd_cnt", rd_cnt - r0, 4);

        // Ignored start while busy, then 5-cycle output back-pressure.
        fill_random();
        start_job(3, 2, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; k_num = KW'(1); m_num = MW'(1);
        @(negedge clk);
        check("ign_cfg_err", cfg_err, 0);
        check("ign_busy", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int d = 0; d < 3; d++) send_block(blocks[d], 1);
        recv_outputs(2, 5, 5);

        // Mid-job reset after the second block, then a fresh job.
        fill_random();
        start_job(4, 2, 1'b1);
        send_block(blocks[0], 0);
        send_block(blocks[1], 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        exp_q.delete();
        exp_addr_q.delete();
        fill_random();
        run_job(2, 2, 1, 2);

        // Random jobs.
        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_job($urandom_range(1, K_MAX), $urandom_range(1, M_MAX), 2, 3);
        end

        check("rd_extra", rd_extra, 0);
        check("out_extra", out_extra, 0);
        check("exp_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
